qsys_pio_gen: RTL and testbench
===============================

Name: qsys_pio_gen

Overview:
- Parametrised general-purpose I/O Avalon-MM slave; next generation of the single-register output PIO.
- Adds per-bit direction, synchronised input sampling, edge capture, interrupt masking and an IRQ output.
- Sits on the Qsys/Platform Designer interconnect and drives board-level control and status pins.

Parameters:
- DATA_WIDTH, 32, number of I/O bits (1..32); bus data is always 32 bits, unused upper bits read 0 and are ignored on write.
- RESET_VALUE, 0, reset value of the output data register (DATA_WIDTH bits).
- RESET_DIR, 0, reset value of the direction register; 1 = output.
- SYNC_STAGES, 2, input synchroniser depth (2..4).
- EDGE_TYPE, 0, capture mode: 0 = rising, 1 = falling, 2 = any edge.

Ports:
- clk  in  1  single system clock.
- reset_n  in  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to clk upstream.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data; combinational, zero wait states.
- in_port  in  DATA_WIDTH  asynchronous pin inputs.
- out_port  out  DATA_WIDTH  output data register.
- oe_port  out  DATA_WIDTH  per-bit output enable (direction register).
- irq  out  1  level interrupt, active high.

Behaviour:
- Write strobe: wr = chipselect & ~write_n. Reads have no side effects.
- Reset: data_out = RESET_VALUE, dir = RESET_DIR, mask = 0, edge_cap = 0, all synchroniser flops 0. Therefore out_port = RESET_VALUE, oe_port = RESET_DIR, irq = 0.
- Register map:
  - 0 DATA: write sets data_out. Read returns per bit: dir ? data_out : in_sync.
  - 1 DIR: read/write.
  - 2 IRQMASK: read/write.
  - 3 EDGECAP: read returns edge_cap. Writing 1 clears that bit; writing 0 has no effect.
  - 4 OUTSET: data_out |= writedata.
  - 5 OUTCLEAR: data_out &= ~writedata.
  - 6, 7: reads return 0; writes are ignored.
- Register write latency: a write takes effect on the clk edge that samples wr. out_port and oe_port change the same cycle.
- Input path: in_port passes through SYNC_STAGES flops to give in_sync. A prev register holds in_sync delayed one cycle. Edge detect:
  - rise = in_sync & ~prev
  - fall = ~in_sync & prev
  - any = rise | fall, selected by EDGE_TYPE.
- Pin-to-capture latency: a pin change sets edge_cap SYNC_STAGES+1 clocks later.
- edge_cap bits latch and stay set until cleared by software.
- Edge capture runs on every bit regardless of direction, so output bits observe their own loopback if the pin is wired back.
- Simultaneous clear and new edge on the same bit in the same cycle: set wins, and the bit stays 1.
- irq = |(edge_cap & mask), registered-free (combinational from registers). It deasserts the cycle after the clearing write.
- Writing 0 to a mask bit suppresses irq but keeps the edge_cap bit set.
- Reset asserted mid-operation: all state clears immediately. No edge is captured on the first cycle after release because prev and in_sync are both 0.

Optional Feature:
- Macro PIO_BIT_MODIFY_EN.
- Defined: addresses 4/5 (OUTSET/OUTCLEAR) are implemented as above.
- Undefined: addresses 4/5 behave like 6/7 (read 0, writes ignored) and their logic is not synthesised.

Decomposition:
- Package qsys_pio_pkg holds:
  - address constants ADDR_DATA..ADDR_OUTCLEAR (3-bit);
  - edge-mode constants EDGE_RISE = 0, EDGE_FALL = 1, EDGE_ANY = 2;
  - the bus width constant BUS_W = 32.
- One sub-module, qsys_pio_sync_edge: vector synchroniser plus prev register and edge decode, parametrised by width, depth and mode. The top level holds registers, the read mux and irq.

Test Plan:
- Reset with RESET_VALUE=32'h0000_00A5, RESET_DIR=32'h0000_00FF -> out_port=A5, oe_port=FF, irq=0; read addr 0 with in_port=0 returns 32'h0000_00A5.
- Write DIR=0x0F, DATA=0xFF, in_port=0xA0, wait 3 clocks -> read addr 0 returns 0xAF.
- EDGE_TYPE=0, mask=0x1, raise in_port[0] -> edge_cap[0]=1 and irq=1 exactly SYNC_STAGES+1 clocks later; write EDGECAP=0x1 -> irq=0 next cycle.
- Clear write to EDGECAP bit 0 in the same cycle a new rising edge reaches the detector -> edge_cap[0] remains 1 and irq stays 1.
- PIO_BIT_MODIFY_EN defined: DATA=0xF0, OUTSET=0x03, OUTCLEAR=0x10 -> out_port=0xE3. Undefined: same sequence -> out_port=0xF0, read addr 4 returns 0.
- Assert reset_n low mid-transfer with edge_cap=0xFF, mask=0xFF -> irq drops without waiting for clk, all registers return to reset values; no spurious capture on release.

Source files
------------

// File: rtl/qsys_pio_pkg.sv
// Shared constants for the qsys_pio_gen Avalon-MM GPIO slave: register
// addresses, edge-capture modes and the fixed bus width.
package qsys_pio_pkg;

    localparam int BUS_W = 32;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK  = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP  = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/qsys_pio_sync_edge.sv
// Multi-stage input synchroniser followed by a one-cycle history register
// and an edge decoder selected by MODE (rise / fall / any).
module qsys_pio_sync_edge
    import qsys_pio_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int MODE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_async,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] edge_det
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]             prev_q, prev_d;
    logic [WIDTH-1:0]             rise, fall;

    always_comb begin
        sync_d[0] = in_async;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[STAGES-1];
    end

    // NOTE: state flops use non-blocking assignment so every stage samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign in_sync = sync_q[STAGES-1];
    assign rise    = in_sync & ~prev_q;
    assign fall    = ~in_sync & prev_q;

    always_comb begin
        case (MODE)
            EDGE_FALL: edge_det = fall;
            EDGE_ANY:  edge_det = rise | fall;
            default:   edge_det = rise;
        endcase
    end

endmodule

// File: rtl/qsys_pio_gen.sv
// Avalon-MM GPIO slave: data/direction/mask/edge-capture registers, read mux
// and level IRQ. OUTSET/OUTCLEAR exist only when PIO_BIT_MODIFY_EN is defined.
module qsys_pio_gen
    import qsys_pio_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_DIR   = '0,
    parameter int                    SYNC_STAGES = 2,
    parameter int                    EDGE_TYPE   = EDGE_RISE
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [BUS_W-1:0]      writedata,
    output logic [BUS_W-1:0]      readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] oe_port,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] dir_q, dir_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [DATA_WIDTH-1:0] cap_q, cap_d;
    logic [DATA_WIDTH-1:0] cap_clr, wdata;
    logic [DATA_WIDTH-1:0] in_sync, edge_det;
    logic                  wr;

    qsys_pio_sync_edge #(
        .WIDTH  (DATA_WIDTH),
        .STAGES (SYNC_STAGES),
        .MODE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_async (in_port),
        .in_sync  (in_sync),
        .edge_det (edge_det)
    );

    assign wr    = chipselect & ~write_n;
    assign wdata = writedata[DATA_WIDTH-1:0];

    // NOTE: every signal written below gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        data_d  = data_q;
        dir_d   = dir_q;
        mask_d  = mask_q;
        cap_clr = '0;
        if (wr) begin
            case (address)
                ADDR_DATA:     data_d  = wdata;
                ADDR_DIR:      dir_d   = wdata;
                ADDR_IRQMASK:  mask_d  = wdata;
                ADDR_EDGECAP:  cap_clr = wdata;
`ifdef PIO_BIT_MODIFY_EN
                ADDR_OUTSET:   data_d  = data_q | wdata;
                ADDR_OUTCLEAR: data_d  = data_q & ~wdata;
`endif
                default: ;
            endcase
        end
        // A new edge overrides a software clear in the same cycle.
        cap_d = (cap_q & ~cap_clr) | edge_det;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
            dir_q  <= RESET_DIR;
            mask_q <= '0;
            cap_q  <= '0;
        end else begin
            data_q <= data_d;
            dir_q  <= dir_d;
            mask_q <= mask_d;
            cap_q  <= cap_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[DATA_WIDTH-1:0] = (dir_q & data_q) | (~dir_q & in_sync);
            ADDR_DIR:     readdata[DATA_WIDTH-1:0] = dir_q;
            ADDR_IRQMASK: readdata[DATA_WIDTH-1:0] = mask_q;
            ADDR_EDGECAP: readdata[DATA_WIDTH-1:0] = cap_q;
            default: ;
        endcase
    end

    assign out_port = data_q;
    assign oe_port  = dir_q;
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_qsys_pio_gen.sv
// Randomised self-checking bench for qsys_pio_gen with a pin-history model;
// honours PIO_BIT_MODIFY_EN the same way the design does.
module tb_qsys_pio_gen;
    import qsys_pio_pkg::*;

    localparam int              DW = 8;
    localparam int              SS = 2;
    localparam int              ET = EDGE_RISE;
    localparam logic [DW-1:0]   RV = 8'hA5;
    localparam logic [DW-1:0]   RD = 8'hFF;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [DW-1:0] in_port;
    logic [DW-1:0] out_port;
    logic [DW-1:0] oe_port;
    logic          irq;

    always #5 clk = ~clk;

    qsys_pio_gen #(
        .DATA_WIDTH  (DW),
        .RESET_VALUE (RV),
        .RESET_DIR   (RD),
        .SYNC_STAGES (SS),
        .EDGE_TYPE   (ET)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .oe_port    (oe_port),
        .irq        (irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: registers plus a history of pin values seen at each
    // clock edge. hist[0] is the newest sample; in_sync is the sample from
    // SS edges ago and the previous synchronised value one edge older.
    logic [DW-1:0] m_data, m_dir, m_mask, m_cap;
    logic [DW-1:0] hist[$];

    function automatic void model_reset();
        m_data = RV;
        m_dir  = RD;
        m_mask = '0;
        m_cap  = '0;
        hist.delete();
        for (int i = 0; i <= SS; i++) hist.push_back('0);
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return 32'((m_dir & m_data) | (~m_dir & hist[SS-1]));
            3'd1:    return 32'(m_dir);
            3'd2:    return 32'(m_mask);
            3'd3:    return 32'(m_cap);
            default: return 32'h0;
        endcase
    endfunction

    task automatic cycle();
        logic [DW-1:0] now_v, old_v, edges, wd, clr;
        if (!reset_n) begin
            model_reset();
        end else begin
            now_v = hist[SS-1];
            old_v = hist[SS];
            case (ET)
                EDGE_FALL: edges = ~now_v & old_v;
                EDGE_ANY:  edges = now_v ^ old_v;
                default:   edges = now_v & ~old_v;
            endcase
            wd  = writedata[DW-1:0];
            clr = '0;
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_data = wd;
                    3'd1: m_dir  = wd;
                    3'd2: m_mask = wd;
                    3'd3: clr    = wd;
`ifdef PIO_BIT_MODIFY_EN
                    3'd4: m_data = m_data | wd;
                    3'd5: m_data = m_data & ~wd;
`endif
                    default: ;
                endcase
            end
            m_cap = (m_cap & ~clr) | edges;
            hist.push_front(in_port);
            void'(hist.pop_back());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_out"}, 32'(out_port), 32'(m_data));
        check({tag, "_oe"},  32'(oe_port),  32'(m_dir));
        check({tag, "_irq"}, 32'(irq),      32'(|(m_cap & m_mask)));
    endtask

    task automatic check_read(input string tag, input logic [2:0] a);
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = a;
        #1;
        check(tag, readdata, m_read(a));
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        cycle();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = '0;
        in_port    = '0;
        model_reset();
        repeat (3) cycle();
        reset_n = 1'b1;

        // Reset state
        check("rst_out", 32'(out_port), 32'h0000_00A5);
        check("rst_oe",  32'(oe_port),  32'h0000_00FF);
        check("rst_irq", 32'(irq),      32'h0);
        address = 3'd0;
        #1;
        check("rst_rd0", readdata, 32'h0000_00A5);

        // Mixed direction readback; upper write bits must be ignored
        bus_write(3'd1, 32'hFFFF_FF0F);
        bus_write(3'd0, 32'h1234_56FF);
        in_port = 8'hA0;
        repeat (3) cycle();
        address = 3'd0;
        #1;
        check("dir_mix", readdata, 32'h0000_00AF);
        check_read("dir_rd", 3'd1);

        // Pin-to-capture latency and clear
        bus_write(3'd3, 32'hFF);
        bus_write(3'd2, 32'h1);
        in_port[0] = 1'b1;
        for (int k = 1; k <= SS + 1; k++) begin
            cycle();
            check($sformatf("lat_irq_%0d", k), 32'(irq), (k == SS + 1) ? 32'h1 : 32'h0);
        end
        check_read("lat_cap", 3'd3);
        bus_write(3'd3, 32'h1);
        check("clr_irq", 32'(irq), 32'h0);

        // Clear and new edge on the same bit in the same cycle
        in_port[0] = 1'b0;
        repeat (SS + 2) cycle();
        bus_write(3'd3, 32'hFF);
        in_port[0] = 1'b1;
        repeat (SS) cycle();
        bus_write(3'd3, 32'h1);
        check("setwin_irq", 32'(irq), 32'h1);
        address = ADDR_EDGECAP;
        #1;
        check("setwin_cap0", 32'(readdata[0]), 32'h1);
        check_outputs("setwin");

        // Bit set / clear
        bus_write(3'd0, 32'hF0);
        bus_write(3'd4, 32'h03);
        bus_write(3'd5, 32'h10);
`ifdef PIO_BIT_MODIFY_EN
        check("bitmod_out", 32'(out_port), 32'hE3);
`else
        check("bitmod_out", 32'(out_port), 32'hF0);
`endif
        address = 3'd4;
        #1;
        check("rd_addr4", readdata, 32'h0);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(3) == 0) in_port = DW'($urandom);
            chipselect = 1'($urandom);
            write_n    = 1'($urandom);
            address    = 3'($urandom);
            writedata  = $urandom;
            cycle();
            check_outputs("rnd");
            check_read("rnd_rd", 3'($urandom));
        end

        // Asynchronous reset with all captures pending and enabled
        bus_write(3'd2, 32'hFF);
        in_port = '0;
        repeat (SS + 2) cycle();
        bus_write(3'd3, 32'hFF);
        in_port = 8'hFF;
        repeat (SS + 1) cycle();
        check("pre_rst_irq", 32'(irq), 32'h1);
        address = ADDR_EDGECAP;
        #1;
        check("pre_rst_cap", readdata, 32'hFF);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_irq", 32'(irq),      32'h0);
        check("arst_out", 32'(out_port), 32'h0000_00A5);
        check("arst_oe",  32'(oe_port),  32'h0000_00FF);
        model_reset();
        cycle();
        reset_n = 1'b1;
        cycle();
        address = ADDR_EDGECAP;
        #1;
        check("rel_cap", readdata, 32'h0);
        check_read("rel_mask", 3'd2);
        for (int k = 0; k < SS + 2; k++) begin
            cycle();
            check_outputs("post_rel");
            check_read("post_rel_cap", 3'd3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
